pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-level sequencer for the pong ball/paddle datapath. It runs the attract, serve, play, miss and game-over phases from the frame tick, start button, paddle-hit and miss events. It gates ball and paddle motion, requests ball reloads, keeps BCD score and lives, and raises the speed level. It sits between the VGA frame tick and the ball/paddle update logic; the RGB mux reads its outputs for the score/lives overlay.

Parameters:
LIVES, 3, lives at game start (1..3)
SERVE_FRAMES, 60, ticks ball is held at serve position before release
MISS_FRAMES, 30, ticks of freeze after a miss
HITS_PER_LEVEL, 4, consecutive paddle hits per speed increment
MAX_LEVEL, 3, saturating speed level (<=3)

Ports:
CLK  in  1  system clock (12 MHz)
RST_N  in  1  asynchronous active-low reset
tick  in  1  one-CLK pulse per frame (y==481, x==0)
start_button  in  1  raw, active-low, asynchronous push button
hit  in  1  one-CLK pulse, ball contacted paddle
miss  in  1  one-CLK pulse, ball passed right boundary
ball_load  out  1  one-CLK pulse: reload ball to serve position/velocity
ball_run  out  1  level: ball may advance on tick
paddle_run  out  1  level: paddle may move on tick
speed  out  2  speed level 0..MAX_LEVEL
score_tens  out  4  BCD tens digit
score_ones  out  4  BCD ones digit
lives  out  2  remaining lives
state  out  3  current FSM state code
game_over  out  1  high while in OVER

Behaviour:
- All outputs are registered. Reset (RST_N low, asynchronous, at any time including mid-game): state=ATTRACT, ball_load=0, ball_run=0, paddle_run=0, speed=0, score=00, lives=0, game_over=0, frame_cnt=0, hit_cnt=0, sync flops=1.
- start_button passes through a 2-flop synchronizer and a falling-edge detector. The resulting press pulse is one CLK wide, 3 CLKs after the pin falls. Holding the button produces one press.
- States: ATTRACT=0, SERVE=1, PLAY=2, MISS=3, OVER=4. Codes 5-7 are illegal and go to ATTRACT on the next CLK.
- ATTRACT: paddle_run=1, ball_run=0. On press: score=00, lives=LIVES, speed=0, hit_cnt=0, go to SERVE.
- SERVE: on the first CLK in SERVE, ball_load=1 for exactly one CLK and frame_cnt=0. ball_run=0, paddle_run=1. frame_cnt increments on each tick. On the tick that makes frame_cnt==SERVE_FRAMES, go to PLAY.
- PLAY: ball_run=1, paddle_run=1.
  - hit: score +1 in BCD (ones 9 -> 0 with tens +1). Score saturates at 99; further hits leave it at 99.
  - hit also increments hit_cnt. When hit_cnt reaches HITS_PER_LEVEL: hit_cnt=0 and speed +1, saturating at MAX_LEVEL.
  - miss: lives -1, hit_cnt=0, speed=0, frame_cnt=0, go to MISS.
  - hit and miss in the same CLK: miss wins and the hit is discarded.
- MISS: ball_run=0, paddle_run=0, frame_cnt counts ticks. At frame_cnt==MISS_FRAMES: go to OVER if lives==0, else go to SERVE.
- OVER: game_over=1, ball_run=0, paddle_run=0. Score and lives are held for display. A press starts a new game exactly as from ATTRACT.
- hit/miss outside PLAY are ignored. A press outside ATTRACT/OVER is ignored.
- tick and hit in the same CLK are independent; both take effect.
- Each transition occurs on the CLK edge after the qualifying event; the new outputs are valid in the same cycle as the new state.

Test Plan:
- Reset mid-PLAY with score=12, lives=2 -> RST_N low gives state=0 and score=00 immediately; after release the block stays in ATTRACT with lives=0.
- Start press in ATTRACT, LIVES=3 -> SERVE in press+1 CLK, lives=3, ball_load high exactly 1 CLK; PLAY after 60 ticks, ball_run=1.
- 9 hits in PLAY with HITS_PER_LEVEL=4 -> score 09, speed=2, hit_cnt=1. One more hit -> score 10, speed stays 2. Preload score 99, hit -> stays 99.
- hit and miss in the same CLK with score=05, lives=3 -> score 05, lives=2, speed=0, MISS. After 30 ticks -> SERVE with a ball_load pulse.
- Three misses -> after the third MISS window, OVER with game_over=1, score held. Start press -> SERVE, score=00, lives=3.
- Start held low for 1000 CLKs during ATTRACT -> exactly one transition. A 2-CLK glitch on start_button in PLAY -> no state change.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game phase sequencer for the pong datapath.
// Gates ball/paddle motion, requests serves, keeps BCD score, lives and speed.
module pong_game_ctrl #(
    parameter int LIVES          = 3,
    parameter int SERVE_FRAMES   = 60,
    parameter int MISS_FRAMES    = 30,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_LEVEL      = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       tick,
    input  logic       start_button,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_load,
    output logic       ball_run,
    output logic       paddle_run,
    output logic [1:0] speed,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over
);
    localparam int FMAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int HW   = $clog2(HITS_PER_LEVEL + 1);

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_MISS    = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    state_t        r_state, w_state_nx;
    logic          r_s1, r_s2, r_s3, r_press;
    logic [FW-1:0] r_frame, w_frame_nx;
    logic [HW-1:0] r_hits, w_hits_nx;
    logic [1:0]    r_speed, w_speed_nx;
    logic [1:0]    r_lives, w_lives_nx;
    logic [3:0]    r_tens, w_tens_nx;
    logic [3:0]    r_ones, w_ones_nx;
    logic          r_ball_load, r_ball_run, r_paddle_run, r_game_over;
    logic          w_new_game;

    always_comb begin
        w_state_nx = r_state;
        w_frame_nx = r_frame;
        w_hits_nx  = r_hits;
        w_speed_nx = r_speed;
        w_lives_nx = r_lives;
        w_tens_nx  = r_tens;
        w_ones_nx  = r_ones;
        w_new_game = 1'b0;
        case (r_state)
            ST_ATTRACT, ST_OVER: begin
                if (r_press) begin
                    w_new_game = 1'b1;
                    w_state_nx = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (r_frame == FW'(SERVE_FRAMES - 1))
                        w_state_nx = ST_PLAY;
                    else
                        w_frame_nx = r_frame + FW'(1);
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    w_lives_nx = r_lives - 2'd1;
                    w_hits_nx  = '0;
                    w_speed_nx = 2'd0;
                    w_state_nx = ST_MISS;
                end else if (hit) begin
                    // BCD increment, saturating at 99
                    if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
                        if (r_ones == 4'd9) begin
                            w_ones_nx = 4'd0;
                            w_tens_nx = r_tens + 4'd1;
                        end else begin
                            w_ones_nx = r_ones + 4'd1;
                        end
                    end
                    if (r_hits == HW'(HITS_PER_LEVEL - 1)) begin
                        w_hits_nx = '0;
                        if (r_speed != 2'(MAX_LEVEL))
                            w_speed_nx = r_speed + 2'd1;
                    end else begin
                        w_hits_nx = r_hits + HW'(1);
                    end
                end
            end
            ST_MISS: begin
                if (tick) begin
                    if (r_frame == FW'(MISS_FRAMES - 1))
                        w_state_nx = (r_lives == 2'd0) ? ST_OVER : ST_SERVE;
                    else
                        w_frame_nx = r_frame + FW'(1);
                end
            end
            default: w_state_nx = ST_ATTRACT;
        endcase
        if (w_new_game) begin
            w_tens_nx  = 4'd0;
            w_ones_nx  = 4'd0;
            w_lives_nx = 2'(LIVES);
            w_speed_nx = 2'd0;
            w_hits_nx  = '0;
        end
        // every phase that counts frames starts from zero
        if (w_state_nx != r_state)
            w_frame_nx = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_ATTRACT;
            r_s1         <= 1'b1;
            r_s2         <= 1'b1;
            r_s3         <= 1'b1;
            r_press      <= 1'b0;
            r_frame      <= '0;
            r_hits       <= '0;
            r_speed      <= 2'd0;
            r_lives      <= 2'd0;
            r_tens       <= 4'd0;
            r_ones       <= 4'd0;
            r_ball_load  <= 1'b0;
            r_ball_run   <= 1'b0;
            r_paddle_run <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_s1         <= start_button;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_press      <= r_s3 & ~r_s2;
            r_state      <= w_state_nx;
            r_frame      <= w_frame_nx;
            r_hits       <= w_hits_nx;
            r_speed      <= w_speed_nx;
            r_lives      <= w_lives_nx;
            r_tens       <= w_tens_nx;
            r_ones       <= w_ones_nx;
            r_ball_load  <= (w_state_nx == ST_SERVE) && (r_state != ST_SERVE);
            r_ball_run   <= (w_state_nx == ST_PLAY);
            r_paddle_run <= (w_state_nx == ST_ATTRACT) || (w_state_nx == ST_SERVE)
                            || (w_state_nx == ST_PLAY);
            r_game_over  <= (w_state_nx == ST_OVER);
        end
    end

    assign ball_load  = r_ball_load;
    assign ball_run   = r_ball_run;
    assign paddle_run = r_paddle_run;
    assign speed      = r_speed;
    assign score_tens = r_tens;
    assign score_ones = r_ones;
    assign lives      = r_lives;
    assign state      = r_state;
    assign game_over  = r_game_over;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios plus random play,
// scored against a game-level reference model through an expectation queue.
module tb_pong_game_ctrl;
    localparam int LIVES = 3;
    localparam int SERVE_FRAMES = 60;
    localparam int MISS_FRAMES = 30;
    localparam int HITS_PER_LEVEL = 4;
    localparam int MAX_LEVEL = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       tick = 1'b0;
    logic       start_button = 1'b1;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       ball_load, ball_run, paddle_run, game_over;
    logic [1:0] speed, lives;
    logic [3:0] score_tens, score_ones;
    logic [2:0] state;

    pong_game_ctrl #(
        .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .MISS_FRAMES(MISS_FRAMES),
        .HITS_PER_LEVEL(HITS_PER_LEVEL), .MAX_LEVEL(MAX_LEVEL)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .tick(tick), .start_button(start_button),
        .hit(hit), .miss(miss), .ball_load(ball_load), .ball_run(ball_run),
        .paddle_run(paddle_run), .speed(speed), .score_tens(score_tens),
        .score_ones(score_ones), .lives(lives), .state(state), .game_over(game_over)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       load;
        logic       brun;
        logic       prun;
        logic [1:0] speed;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] lives;
        logic [2:0] st;
        logic       go;
    } exp_t;

    exp_t q[$];
    exp_t e_m, g_m;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic want_rst = 1'b0;

    // reference game: 0 attract, 1 serve, 2 play, 3 miss, 4 over
    int m_mode, m_cnt, m_hits, m_speed, m_score, m_lives;
    bit m_load;
    bit p1, p2, p3, p4;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_hits = 0; m_speed = 0;
        m_score = 0; m_lives = 0; m_load = 0;
        p1 = 1; p2 = 1; p3 = 1; p4 = 1;
    endtask

    task automatic model_edge(input bit t, input bit b, input bit h, input bit m);
        int prev;
        bit press;
        prev = m_mode;
        // a press is a 1->0 pin change seen four and three edges back
        press = p4 && !p3;
        p4 = p3; p3 = p2; p2 = p1; p1 = b;
        if (m_mode == 0 || m_mode == 4) begin
            if (press) begin
                m_score = 0; m_lives = LIVES; m_speed = 0; m_hits = 0;
                m_mode = 1; m_cnt = 0;
            end
        end else if (m_mode == 1) begin
            if (t) begin
                m_cnt++;
                if (m_cnt == SERVE_FRAMES) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (m) begin
                m_lives--; m_hits = 0; m_speed = 0; m_cnt = 0; m_mode = 3;
            end else if (h) begin
                if (m_score < 99) m_score++;
                m_hits++;
                if (m_hits == HITS_PER_LEVEL) begin
                    m_hits = 0;
                    if (m_speed < MAX_LEVEL) m_speed++;
                end
            end
        end else if (m_mode == 3) begin
            if (t) begin
                m_cnt++;
                if (m_cnt == MISS_FRAMES) begin
                    m_mode = (m_lives == 0) ? 4 : 1;
                    m_cnt = 0;
                end
            end
        end
        m_load = (m_mode == 1) && (prev != 1);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.load  = m_load;
        e.brun  = (m_mode == 2);
        e.prun  = (m_mode <= 2);
        e.speed = 2'(m_speed);
        e.tens  = 4'(m_score / 10);
        e.ones  = 4'(m_score % 10);
        e.lives = 2'(m_lives);
        e.st    = 3'(m_mode);
        e.go    = (m_mode == 4);
        return e;
    endfunction

    task automatic step(input bit t, input bit b, input bit h, input bit m);
        @(negedge CLK);
        RST_N = want_rst;
        tick = t; start_button = b; hit = h; miss = m;
        if (!RST_N) begin
            model_reset();
            q.push_back('0);
        end else begin
            model_edge(t, b, h, m);
            q.push_back(model_out());
        end
    endtask

    task automatic go_until(input int target, input int bound);
        int n;
        n = 0;
        while (m_mode != target && n < bound) begin
            step(1, 1, 0, 0);
            n++;
        end
        if (m_mode != target) begin
            total++; bad++;
            $display("FAIL go_until target=%0d stuck_at=%0d", target, m_mode);
        end
    endtask

    task automatic mid_reset();
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        want_rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL async_rst_state got=%0d exp=0", state);
        end
        total++;
        if ({score_tens, score_ones} !== 8'h00) begin
            bad++;
            $display("FAIL async_rst_score got=%h%h exp=00", score_tens, score_ones);
        end
    endtask

    always @(posedge CLK) begin
        cyc++;
        #1;
        if (q.size() > 0) begin
            e_m = q.pop_front();
            g_m.load  = ball_load;
            g_m.brun  = ball_run;
            g_m.prun  = paddle_run;
            g_m.speed = speed;
            g_m.tens  = score_tens;
            g_m.ones  = score_ones;
            g_m.lives = lives;
            g_m.st    = state;
            g_m.go    = game_over;
            total++;
            if (g_m !== e_m) begin
                bad++;
                $display("FAIL outputs cyc=%0d got st=%0d ld=%b br=%b pr=%b sp=%0d sc=%h%h lv=%0d go=%b exp st=%0d ld=%b br=%b pr=%b sp=%0d sc=%h%h lv=%0d go=%b",
                         cyc, g_m.st, g_m.load, g_m.brun, g_m.prun, g_m.speed,
                         g_m.tens, g_m.ones, g_m.lives, g_m.go,
                         e_m.st, e_m.load, e_m.brun, e_m.prun, e_m.speed,
                         e_m.tens, e_m.ones, e_m.lives, e_m.go);
            end
        end
    end

    initial begin
        bit b;
        int n;
        model_reset();
        want_rst = 1'b0;
        repeat (3) step(0, 1, 0, 0);
        want_rst = 1'b1;
        repeat (5) step(0, 1, 0, 0);
        // button held: one press only
        repeat (1000) step(($urandom % 8) == 0, 0, 0, 0);
        step(0, 1, 0, 0);
        go_until(2, 200);
        for (int i = 0; i < 9; i++) begin
            step($urandom % 2, 1, 1, 0);
            step(0, 1, 0, 0);
        end
        step(0, 1, 1, 0);
        // short glitch during play
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0);
        step(1, 1, 1, 1);
        go_until(1, 100);
        go_until(2, 100);
        repeat (2) step(0, 1, 1, 0);
        mid_reset();
        repeat (2) step(0, 1, 0, 0);
        want_rst = 1'b1;
        repeat (10) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        go_until(2, 300);
        for (int k = 0; k < 3; k++) begin
            repeat (3) step(0, 1, 1, 0);
            step(0, 1, 0, 1);
            go_until((k == 2) ? 4 : 1, 100);
            if (k < 2) go_until(2, 100);
        end
        repeat (5) step(1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        go_until(2, 200);
        repeat (5) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        go_until(1, 100);
        go_until(2, 100);
        repeat (101) step($urandom % 2, 1, 1, 0);
        b = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 50) == 0) b = ~b;
            step(($urandom % 4) == 0, b, ($urandom % 6) == 0, ($urandom % 40) == 0);
        end
        step(0, 1, 0, 0);
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge CLK);
            #2;
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
